// File: rtl/nmr_echo_acq_if.sv
`default_nettype none
// ============================================================================
// Module   : nmr_echo_acq_if
// Brief    : Tagged-sample output stream (valid/ready) of nmr_echo_acq.
// Revision : 1.0 - initial release
// ============================================================================
interface nmr_echo_acq_if #(
    parameter int DW = 32
);
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          DOUT_READY;

    modport master (
        output DOUT,
        output DOUT_VALID,
        input  DOUT_READY
    );

    modport slave (
        input  DOUT,
        input  DOUT_VALID,
        output DOUT_READY
    );
endinterface
`default_nettype wire

// File: rtl/nmr_echo_acq.sv
`default_nettype none
// ============================================================================
// Module   : nmr_echo_acq
// Brief    : NMR echo acquisition: captures ADC samples inside each echo
//            window, tags them with the echo index and streams them out of
//            a show-ahead FIFO. Optional end-of-scan trailer word when
//            NMR_ACQ_TRAILER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module nmr_echo_acq #(
    parameter int ADC_WIDTH      = 16,
    parameter int ECHO_IDX_WIDTH = 14,
    parameter int FIFO_AW        = 9
) (
    input  wire logic                      CLK,
    input  wire logic                      RESET,
    input  wire logic                      FSMSTAT,
    input  wire logic                      ACQ_WND,
    input  wire logic                      ADC_CLK,
    input  wire logic [ADC_WIDTH-1:0]      ADC_DATA,
    nmr_echo_acq_if.master                 dout_if,
    output logic      [FIFO_AW:0]          FIFO_LEVEL,
    output logic      [ECHO_IDX_WIDTH-1:0] ECHO_CNT,
    output logic                           OVF,
    output logic                           BUSY,
    output logic                           SCAN_DONE
);

    localparam int                      c_WORD_W  = ADC_WIDTH + ECHO_IDX_WIDTH + 2;
    localparam int                      c_DEPTH_N = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]        c_DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]        c_LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0]      c_PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [ECHO_IDX_WIDTH-1:0] c_IDX_ONE = {{(ECHO_IDX_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic                      r_adc_q;
    logic                      r_wnd_q;
    logic [ECHO_IDX_WIDTH-1:0] r_echo_cnt;
    logic                      r_first;
    logic                      r_ovf;

    logic [c_WORD_W-1:0]       r_mem [c_DEPTH_N];
    logic [FIFO_AW-1:0]        r_wr_ptr;
    logic [FIFO_AW-1:0]        r_rd_ptr;
    logic [FIFO_AW:0]          r_level;

    logic                      w_adc_edge;
    logic                      w_wnd_rise;
    logic                      w_run;
    logic                      w_scan_start;
    logic                      w_capture;
    logic                      w_lost;
    logic [ECHO_IDX_WIDTH-1:0] w_cap_idx;
    logic [c_WORD_W-1:0]       w_cap_word;
    logic                      w_push_req;
    logic [c_WORD_W-1:0]       w_push_word;
    logic                      w_flush_done;
    logic                      w_full;
    logic                      w_valid;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;

    // ADC_CLK is sampled as data in the CLK domain; its rising edge marks a sample
    assign w_adc_edge   = ADC_CLK & ~r_adc_q;
    assign w_wnd_rise   = ACQ_WND & ~r_wnd_q;
    assign w_run        = (r_state == c_ST_RUN);
    assign w_scan_start = (r_state == c_ST_IDLE) & FSMSTAT;
    assign w_capture    = w_run & ACQ_WND & w_adc_edge;
    assign w_lost       = ~w_run & FSMSTAT & ACQ_WND & w_adc_edge;

    // A capture coinciding with the window rise already belongs to the new echo
    assign w_cap_idx  = w_wnd_rise ? r_echo_cnt : (r_echo_cnt - c_IDX_ONE);
    assign w_cap_word = {((r_first | w_wnd_rise) ? 2'b01 : 2'b00), w_cap_idx, ADC_DATA};

    assign w_full  = (r_level == c_DEPTH);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & dout_if.DOUT_READY;
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

`ifdef NMR_ACQ_TRAILER_EN
    localparam logic [ADC_WIDTH-2:0] c_SAMP_ONE = {{(ADC_WIDTH-2){1'b0}}, 1'b1};

    logic                 r_trl_pend;
    logic [ADC_WIDTH-2:0] r_samp_cnt;
    logic                 w_trl_push;

    // Trailer only goes in when there is free space, so it can never be dropped
    assign w_trl_push   = (r_state == c_ST_FLUSH) & r_trl_pend & ~w_full;
    assign w_push_req   = w_capture | w_trl_push;
    assign w_push_word  = w_trl_push ? {2'b10, r_echo_cnt, r_ovf, r_samp_cnt} : w_cap_word;
    assign w_flush_done = ~r_trl_pend & ~w_valid;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_trl_pend <= 1'b0;
            r_samp_cnt <= '0;
        end else begin
            if (w_scan_start) begin
                r_samp_cnt <= '0;
            end else if (w_run & w_wnd_rise) begin
                r_samp_cnt <= w_capture ? c_SAMP_ONE : '0;
            end else if (w_capture) begin
                r_samp_cnt <= r_samp_cnt + c_SAMP_ONE;
            end

            if (w_run & ~FSMSTAT) begin
                r_trl_pend <= 1'b1;
            end else if (w_trl_push) begin
                r_trl_pend <= 1'b0;
            end
        end
    end
`else
    assign w_push_req   = w_capture;
    assign w_push_word  = w_cap_word;
    assign w_flush_done = ~w_valid;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_adc_q <= 1'b0;
            r_wnd_q <= 1'b0;
        end else begin
            r_adc_q <= ADC_CLK;
            r_wnd_q <= ACQ_WND;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= c_ST_IDLE;
            r_echo_cnt <= '0;
            r_first    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (FSMSTAT) begin
                        r_state    <= c_ST_RUN;
                        r_echo_cnt <= '0;
                        r_first    <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (w_wnd_rise) begin
                        r_echo_cnt <= r_echo_cnt + c_IDX_ONE;
                        r_first    <= 1'b1;
                    end
                    if (w_capture) begin
                        r_first <= 1'b0;
                    end
                    if (!FSMSTAT) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (w_flush_done) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // A sample lost in the start cycle is charged to the scan being started
            if (w_scan_start) begin
                r_ovf <= w_lost;
            end else if (w_lost | w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Show-ahead head word; forced to zero while empty so reset shows DOUT=0
    assign dout_if.DOUT       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign dout_if.DOUT_VALID = w_valid;

    assign FIFO_LEVEL = r_level;
    assign ECHO_CNT   = r_echo_cnt;
    assign OVF        = r_ovf;
    assign BUSY       = (r_state != c_ST_IDLE);
    assign SCAN_DONE  = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nmr_echo_acq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmr_echo_acq
// Brief    : Self-checking bench for nmr_echo_acq (small FIFO, echo-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmr_echo_acq;

    localparam int AW  = 16;
    localparam int IW  = 14;
    localparam int FAW = 3;
    localparam int DW  = AW + IW + 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          FSMSTAT;
    logic          ACQ_WND;
    logic          ADC_CLK;
    logic [AW-1:0] ADC_DATA;
    logic [FAW:0]  FIFO_LEVEL;
    logic [IW-1:0] ECHO_CNT;
    logic          OVF;
    logic          BUSY;
    logic          SCAN_DONE;

    nmr_echo_acq_if #(.DW(DW)) dif ();

    nmr_echo_acq #(
        .ADC_WIDTH      (AW),
        .ECHO_IDX_WIDTH (IW),
        .FIFO_AW        (FAW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FSMSTAT    (FSMSTAT),
        .ACQ_WND    (ACQ_WND),
        .ADC_CLK    (ADC_CLK),
        .ADC_DATA   (ADC_DATA),
        .dout_if    (dif.master),
        .FIFO_LEVEL (FIFO_LEVEL),
        .ECHO_CNT   (ECHO_CNT),
        .OVF        (OVF),
        .BUSY       (BUSY),
        .SCAN_DONE  (SCAN_DONE)
    );

    always #5 CLK = ~CLK;

    int            vectors = 0;
    int            miscompares = 0;
    int            pops = 0;
    int            adc_ph = 0;
    int            rdy_mode = 0;
    int            m_echo = 0;
    int            m_last_cnt = 0;
    logic          m_first = 1'b0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_dout = '0;
    logic          prev_hold = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_rdy();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 2) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One CLK cycle. ADC_CLK = CLK/4 with its rising edge at phase 2; every
    // rising edge inside an open window is one expected sample of the echo.
    task automatic step(input logic wnd, input logic rdy);
        logic [1:0] tg;
        ACQ_WND        = wnd;
        dif.DOUT_READY = rdy;
        ADC_CLK        = ((adc_ph % 4) >= 2);
        ADC_DATA       = AW'($urandom);
        if (wnd && (adc_ph % 4) == 2) begin
            tg = m_first ? 2'b01 : 2'b00;
            exp_q.push_back({tg, IW'(m_echo), ADC_DATA});
            m_first = 1'b0;
            m_last_cnt++;
        end
        @(posedge CLK);
        #1;
        adc_ph++;
    endtask

    task automatic begin_echo(input int k);
        m_first    = 1'b1;
        m_echo     = k;
        m_last_cnt = 0;
    endtask

    task automatic echo_t(input int k, input int wlen, input int gap);
        begin_echo(k);
        for (int i = 0; i < wlen; i++) step(1'b1, get_rdy());
        for (int i = 0; i < gap; i++) step(1'b0, get_rdy());
    endtask

    task automatic start_scan();
        FSMSTAT    = 1'b1;
        m_last_cnt = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("busy_in_scan", 64'(BUSY), 64'(1));
    endtask

    task automatic expect_trailer(input int n, input logic ovf);
`ifdef NMR_ACQ_TRAILER_EN
        logic [IW-1:0] ti;
        logic [AW-2:0] ts;
        ti = IW'(n);
        ts = m_last_cnt[AW-2:0];
        exp_q.push_back({2'b10, ti, ovf, ts});
`else
        if (n < 0 || ovf) m_last_cnt = m_last_cnt;
`endif
    endtask

    task automatic end_scan(input int n, input logic ovf);
        logic seen;
        FSMSTAT = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1'b0, 1'b1);
            if (SCAN_DONE) seen = 1'b1;
        end
        check("scan_done_seen", 64'(seen), 64'(1));
        check("echo_cnt", 64'(ECHO_CNT), 64'(IW'(n)));
        check("ovf_at_done", 64'(OVF), 64'(ovf));
        check("exp_drained", 64'(exp_q.size()), 64'(0));
        step(1'b0, 1'b1);
        check("scan_done_pulse", 64'(SCAN_DONE), 64'(0));
        check("idle_after_done", 64'(BUSY), 64'(0));
    endtask

    task automatic finish_scan(input int n, input logic ovf);
        expect_trailer(n, ovf);
        end_scan(n, ovf);
    endtask

    // Consumer-side monitor: every accepted word must be the model's next word
    always @(negedge CLK) begin
        if (RESET) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && dif.DOUT_VALID)
                check("dout_hold", 64'(dif.DOUT), 64'(prev_dout));
            if (dif.DOUT_VALID && dif.DOUT_READY) begin
                pops++;
                check("exp_avail", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) check("dout_word", 64'(dif.DOUT), 64'(exp_q.pop_front()));
            end
            prev_hold = dif.DOUT_VALID && !dif.DOUT_READY;
            prev_dout = dif.DOUT;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        int ntr;
`ifdef NMR_ACQ_TRAILER_EN
        ntr = 1;
`else
        ntr = 0;
`endif
        RESET = 1'b1; FSMSTAT = 1'b0; ACQ_WND = 1'b0; ADC_CLK = 1'b0;
        ADC_DATA = '0; dif.DOUT_READY = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        RESET = 1'b0;
        step(1'b0, 1'b0);
        check("rst_valid", 64'(dif.DOUT_VALID), 64'(0));
        check("rst_dout", 64'(dif.DOUT), 64'(0));
        check("rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("rst_echo_cnt", 64'(ECHO_CNT), 64'(0));
        check("rst_ovf", 64'(OVF), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_scan_done", 64'(SCAN_DONE), 64'(0));

        // Single 40-cycle echo -> 10 samples
        rdy_mode = 0;
        p0 = pops;
        start_scan();
        echo_t(0, 40, 4);
        finish_scan(1, 1'b0);
        check("single_echo_words", 64'(pops - p0), 64'(10 + ntr));

        // Three 8-cycle echoes -> 2 samples each
        p0 = pops;
        start_scan();
        for (int k = 0; k < 3; k++) echo_t(k, 8, 4);
        finish_scan(3, 1'b0);
        check("three_echo_words", 64'(pops - p0), 64'(6 + ntr));

        // Two echoes x 3 samples (trailer low bits = 3 when enabled)
        p0 = pops;
        start_scan();
        for (int k = 0; k < 2; k++) echo_t(k, 12, 4);
        finish_scan(2, 1'b0);
        check("two_echo_words", 64'(pops - p0), 64'(6 + ntr));

        // Overflow: 12 samples into an 8-deep FIFO with no consumer
        rdy_mode = 2;
        start_scan();
        echo_t(0, 48, 4);
        check("ovf_level", 64'(FIFO_LEVEL), 64'(8));
        check("ovf_set", 64'(OVF), 64'(1));
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        expect_trailer(1, 1'b1);
        FSMSTAT = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("ovf_flush_level", 64'(FIFO_LEVEL), 64'(8));
        check("ovf_flush_busy", 64'(BUSY), 64'(1));
        end_scan(1, 1'b1);
        start_scan();
        check("ovf_cleared", 64'(OVF), 64'(0));
        finish_scan(0, 1'b0);

        // Full FIFO with simultaneous push and pop
        start_scan();
        begin_echo(0);
        for (int i = 0; i < 100 && FIFO_LEVEL != 8; i++) step(1'b1, 1'b0);
        check("full_level", 64'(FIFO_LEVEL), 64'(8));
        for (int i = 0; i < 4 && (adc_ph % 4) != 2; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("full_pushpop_level", 64'(FIFO_LEVEL), 64'(8));
        check("full_pushpop_ovf", 64'(OVF), 64'(0));
        step(1'b0, 1'b0);
        finish_scan(1, 1'b0);

        // Reset in the middle of an echo with 5 words buffered
        rdy_mode = 2;
        start_scan();
        begin_echo(0);
        for (int i = 0; i < 100 && FIFO_LEVEL != 5; i++) step(1'b1, 1'b0);
        check("mid_level", 64'(FIFO_LEVEL), 64'(5));
        RESET = 1'b1;
        step(1'b1, 1'b0);
        check("mid_rst_valid", 64'(dif.DOUT_VALID), 64'(0));
        check("mid_rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("mid_rst_busy", 64'(BUSY), 64'(0));
        check("mid_rst_echo", 64'(ECHO_CNT), 64'(0));
        exp_q.delete();
        RESET = 1'b0; FSMSTAT = 1'b0;
        step(1'b0, 1'b1);
        rdy_mode = 0;
        p0 = pops;
        start_scan();
        echo_t(0, 40, 4);
        finish_scan(1, 1'b0);
        check("post_rst_words", 64'(pops - p0), 64'(10 + ntr));

        // Randomised scans: random echo widths (some too narrow for a sample),
        // gaps and consumer back-pressure
        rdy_mode = 1;
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 4);
            start_scan();
            for (int k = 0; k < n; k++) echo_t(k, $urandom_range(1, 14), $urandom_range(2, 6));
            finish_scan(n, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nmr_echo_acq.md
Name: nmr_echo_acq

Overview:
- Receive-side counterpart to the NMR pulse-program sequencer.
- Consumes FSMSTAT, ACQ_WND and ADC_CLK from the sequencer, together with parallel ADC sample data.
- Captures one sample per ADC_CLK rising edge while the acquisition window is open and tags each sample with its echo index.
- Buffers the tagged words in a show-ahead FIFO and presents them on a valid/ready stream to the host/DMA side. It also reports per-scan status: overflow, echo count and scan-done.

Parameters:
ADC_WIDTH, 16, ADC sample width
ECHO_IDX_WIDTH, 14, echo index field width
FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW words

Ports:
CLK  in  1  system clock; same clock domain as the sequencer
RESET  in  1  asynchronous, active-high reset
FSMSTAT  in  1  sequencer busy; high for the whole scan
ACQ_WND  in  1  acquisition window; one high pulse per echo
ADC_CLK  in  1  ADC clock (CLK/4), synchronous to CLK; treated as data
ADC_DATA  in  ADC_WIDTH  ADC sample, valid around the ADC_CLK rising edge
DOUT  out  ADC_WIDTH+ECHO_IDX_WIDTH+2  {TAG[1:0], ECHO_IDX, SAMPLE}
DOUT_VALID  out  1  FIFO not empty
DOUT_READY  in  1  consumer accepts DOUT this cycle
FIFO_LEVEL  out  FIFO_AW+1  words currently stored
ECHO_CNT  out  ECHO_IDX_WIDTH  echoes seen in the current or last scan
OVF  out  1  sticky overflow: at least one sample dropped this scan
BUSY  out  1  state is not IDLE
SCAN_DONE  out  1  one-cycle pulse at the end of a scan

Behaviour:
- Reset values:
  - state IDLE; FIFO emptied; DOUT_VALID=0; DOUT=0; FIFO_LEVEL=0.
  - ECHO_CNT=0; OVF=0; BUSY=0; SCAN_DONE=0; adc_clk_q=0; wnd_q=0.
- ADC edge detect: adc_edge = ADC_CLK & ~adc_clk_q, where adc_clk_q is ADC_CLK registered each CLK.
- Window edge detect: wnd_rise = ACQ_WND & ~wnd_q.
- State machine (registered, one-hot or binary):
  - IDLE: when FSMSTAT=1, go to RUN; clear ECHO_CNT, OVF and the first-flag.
  - RUN:
    - On wnd_rise: ECHO_CNT increments and first-flag is set.
    - Sample capture condition: state RUN & ACQ_WND=1 & adc_edge.
    - Captured word: TAG=01 if first-flag is set (first-flag then clears), else 00; ECHO_IDX=ECHO_CNT-1 (post-increment value when wnd_rise coincides); SAMPLE=ADC_DATA of that cycle.
    - Leave for FLUSH when FSMSTAT=0.
  - FLUSH: stay until the FIFO is empty (plus trailer push, see Optional Feature), then go to DONE.
  - DONE: SCAN_DONE=1 for exactly 1 cycle, then IDLE.
- A FSMSTAT high seen in FLUSH or DONE does not start a scan; the new scan starts in IDLE.
- Any ACQ_WND&adc_edge in FLUSH, DONE or IDLE while FSMSTAT=1 sets OVF (the sample is lost). This OVF is set after the IDLE clear, i.e. it is reported for the new scan.
- ECHO_CNT and ECHO_IDX wrap modulo 2^ECHO_IDX_WIDTH.
- FIFO:
  - Sample written at the capture clock edge.
  - DOUT/DOUT_VALID are show-ahead and update 1 cycle after the write when the FIFO was empty.
  - Pop on DOUT_VALID & DOUT_READY.
  - DOUT holds stable while DOUT_VALID=1 and DOUT_READY=0.
- Full handling:
  - Push while full with a simultaneous pop: accepted; level unchanged.
  - Push while full without a pop: word dropped, OVF set, level unchanged.
- OVF stays set until the next IDLE->RUN transition.
- DOUT_READY with the FIFO empty: no effect.
- FIFO_LEVEL is exact and updated every cycle.
- A window narrower than one ADC_CLK period may yield 0 samples. ECHO_CNT still increments; the next echo's first sample carries its own index.
- RESET mid-scan: everything returns to reset values immediately; buffered data is discarded.

Optional Feature:
- Macro: NMR_ACQ_TRAILER_EN.
- Defined:
  - On entering FLUSH, one trailer word is pushed: TAG=10, ECHO_IDX=ECHO_CNT, SAMPLE={OVF, samples-in-last-echo modulo 2^(ADC_WIDTH-1)}.
  - The trailer is never dropped: if the FIFO is full it waits for space, then pushes.
  - Trailer push occurs before the empty check; SCAN_DONE follows the trailer being popped.
- Undefined: no trailer; TAG=10 is never produced; FLUSH only waits for empty.

Test Plan:
- Single echo: FSMSTAT high, ACQ_WND high 40 CLK, ADC_CLK period 4, ADC_DATA=ramp, DOUT_READY=1 -> 10 words; word0 TAG=01 IDX=0; words1-9 TAG=00 IDX=0; ECHO_CNT=1; SCAN_DONE 1 cycle after FSMSTAT falls and FIFO empty.
- Three echoes of 8 CLK each, separated by 4 CLK low -> 2 samples per echo; TAG=01 at IDX 0,1,2; ECHO_CNT=3; OVF=0.
- FIFO_AW=3, DOUT_READY=0, 12 samples -> FIFO_LEVEL=8, OVF=1, first 8 words retained in order; then READY=1 -> 8 pops, SCAN_DONE; next scan start clears OVF.
- Full FIFO (level 8) with push and pop in the same cycle -> level stays 8, OVF stays 0, pushed word appears last.
- RESET asserted mid-echo with level 5 -> next cycle DOUT_VALID=0, FIFO_LEVEL=0, BUSY=0, ECHO_CNT=0; a fresh scan behaves as in the single-echo scenario.
- NMR_ACQ_TRAILER_EN, 2 echoes x 3 samples -> 7th word TAG=10, IDX=2, SAMPLE MSB=0, low bits=3; SCAN_DONE only after the trailer is popped.
